// File: rtl/top.sv
// Counter source feeding a sink through a ready-registered skid slice.
// Downstream ready only reaches registers, never the source's ready.
module top (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       ready_in,
  output logic [2:0] result
);

  logic       src_valid;
  logic [2:0] src_data;
  logic       src_ready;
  logic       src_hs;

  logic       skid_valid;
  logic [2:0] skid_data;

  logic       out_valid;
  logic [2:0] out_data;

  // src_ready is taken purely from a flop, which keeps ready_in off the source's ready path
  assign src_ready = ~skid_valid;
  assign src_hs    = src_valid & src_ready;
  assign out_valid = skid_valid | src_valid;
  assign out_data  = skid_valid ? skid_data : src_data;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      src_valid <= 1'b0;
      src_data  <= 3'd0;
    end else begin
      src_valid <= 1'b1;
      if (src_hs) src_data <= src_data + 3'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= 3'd0;
    end else if (ready_in) begin
      skid_valid <= 1'b0;
    end else if (src_hs) begin
      skid_valid <= 1'b1;
      skid_data  <= src_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      result <= 3'd0;
    end else if (out_valid && ready_in) begin
      result <= out_data;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed and randomized checks of the counter/skid/sink chain against a
// delivery-order model: beats 0,1,2,... mod 8, one per ready cycle once the source is up.
module tb_top;

  logic       sys_clk;
  logic       rst_n;
  logic       ready_in;
  logic [2:0] result;

  int n_checks;
  int n_fails;

  // reference model state
  logic [2:0] m_result;
  int         m_next;
  int         m_age;

  top dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .ready_in(ready_in),
    .result  (result)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // one clock: apply inputs, advance the model, check result just after the edge
  task automatic step(input logic r, input logic rdy, input string tag);
    rst_n    = r;
    ready_in = rdy;
    @(posedge sys_clk);
    if (!r) begin
      m_result = 3'd0;
      m_next   = 0;
      m_age    = 0;
    end else begin
      // the source's first beat becomes visible one cycle after reset release
      if (m_age >= 1 && rdy) begin
        m_result = 3'(m_next);
        m_next   = (m_next + 1) % 8;
      end
      m_age++;
    end
    #1;
    check(tag, result, m_result);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_result = 3'd0;
    m_next   = 0;
    m_age    = 0;
    rst_n    = 1'b0;
    ready_in = 1'b1;

    // reset with ready high
    step(1'b0, 1'b1, "reset");

    // free-running stream across a wrap
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, "stream");

    // single-cycle stall while result = 2
    step(1'b0, 1'b1, "reset2");
    for (int i = 0; i < 20 && m_result != 3'd2; i++) step(1'b1, 1'b1, "to_two");
    check("at_two", result, 3'd2);
    step(1'b1, 1'b0, "stall1_hold");
    check("stall1_is_two", result, 3'd2);
    step(1'b1, 1'b1, "after_stall1_a");
    check("after_stall1_three", result, 3'd3);
    step(1'b1, 1'b1, "after_stall1_b");
    check("after_stall1_four", result, 3'd4);

    // long stall: result frozen, source advances once
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "stall5_hold");
    check("stall5_frozen", result, 3'd4);
    check("stall5_src_once", dut.src_data, 3'((m_next + 1) % 8));
    check_bit("stall5_skid_full", dut.skid_valid, 1'b1);
    step(1'b1, 1'b1, "stall5_resume_a");
    check("stall5_resume_five", result, 3'd5);
    step(1'b1, 1'b1, "stall5_resume_b");

    // wrap under stall
    for (int i = 0; i < 20 && m_result != 3'd7; i++) step(1'b1, 1'b1, "to_seven");
    check("at_seven", result, 3'd7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "wrap_stall");
    step(1'b1, 1'b1, "wrap_resume_a");
    check("wrap_zero", result, 3'd0);
    step(1'b1, 1'b1, "wrap_resume_b");
    check("wrap_one", result, 3'd1);

    // reset while the skid holds a beat
    step(1'b1, 1'b0, "pre_reset_stall");
    check_bit("pre_reset_skid_full", dut.skid_valid, 1'b1);
    step(1'b0, 1'b1, "mid_reset");
    check("mid_reset_result", result, 3'd0);
    check_bit("mid_reset_skid_clear", dut.skid_valid, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "restart");
    check("restart_value", result, 3'd2);

    // randomized ready pattern with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic r, rdy;
      r   = ($urandom_range(0, 49) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, rdy, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 3 bits.
REQ-002 sys_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 ready_in  input  1  downstream ready; high means the sink accepts a beat this cycle.
REQ-005 result  output  3  last data value accepted by the sink; registered.

Function
REQ-006 The block SHALL contain three stages: source, ready-registered slice ("ready beat" skid buffer), and sink.

Source
REQ-007 The source SHALL hold a 3-bit counter src_data and a registered src_valid.
REQ-008 src_valid SHALL be 0 in the first cycle after reset release and 1 in every later cycle.
REQ-009 src_data SHALL increment by 1, modulo 8 (7 -> 0), only on a source handshake (src_valid & src_ready); otherwise it SHALL hold.

Slice
REQ-010 The slice SHALL hold skid_valid (1 bit) and skid_data (3 bits).
REQ-011 src_ready SHALL equal ~skid_valid, which is a registered value, so there is no combinational path from ready_in to src_ready.
REQ-012 out_valid SHALL equal skid_valid | src_valid.
REQ-013 out_data SHALL equal skid_data when skid_valid = 1, else src_data.
REQ-014 When src_valid & src_ready & ~ready_in: skid_valid <= 1 and skid_data <= src_data.
REQ-015 When ready_in = 1: skid_valid <= 0.
REQ-016 In all other cases skid_valid and skid_data SHALL hold.
REQ-017 The skid buffer SHALL hold at most one beat; while it is full, the source SHALL stall.

Sink
REQ-018 On out_valid & ready_in, result SHALL load out_data; otherwise result SHALL hold.
REQ-019 Each counter value SHALL reach result exactly once, in increasing modulo-8 order, with no loss or duplication under any ready_in pattern.
REQ-020 Latency: a beat accepted from the source with ready_in = 1 SHALL appear on result at the next rising edge.
REQ-021 A beat captured in the skid SHALL appear on result at the first edge where ready_in = 1.
REQ-022 ready_in low for N consecutive cycles SHALL freeze result for those N cycles.
REQ-023 ready_in low for N consecutive cycles SHALL let the source advance at most once in total.
REQ-024 Simultaneous skid full and ready_in = 1: result SHALL load skid_data, skid SHALL clear, and the source SHALL not advance that cycle.

Reset
REQ-025 When rst_n = 0 at a rising edge, the following SHALL clear to 0: src_data, src_valid, skid_valid, skid_data, result.
REQ-026 Reset asserted mid-stream SHALL discard any skid content.
REQ-027 After reset release, the sequence SHALL restart from 0.
REQ-028 ready_in SHALL be ignored while rst_n = 0.

Verification
REQ-029 Reset: rst_n = 0 for 1 cycle, ready_in = 1 -> result = 0.
REQ-030 Reset then ready_in = 1 continuously -> result = 0,1,2,...,7,0,1,... one per cycle, starting 1 cycle after src_valid rises.
REQ-031 Single-cycle stall: ready_in = 0 for one cycle while result = 2 -> result holds 2 for that cycle, then 3, 4, ... with no gap or repeat.
REQ-032 Long stall: ready_in = 0 for 5 cycles -> result frozen 5 cycles; then the next values resume consecutively.
REQ-033 Long stall, counter check: during the 5-cycle stall the source counter advances exactly once.
REQ-034 Wrap under stall: stall while result = 7 -> next values 0, 1 after release.
REQ-035 Mid-stream reset: rst_n = 0 while skid is full -> result = 0, skid_valid = 0; after release the sequence restarts at 0.
